// File: rtl/clint_reg_arbiter.sv
// clint_reg_arbiter: round-robin arbiter sharing the CLINT register port, with a response timeout
module clint_reg_arbiter #(
    parameter int NR_PORTS   = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NR_PORTS-1:0]            req_i,
    input  logic [NR_PORTS-1:0]            we_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0] wdata_i,
    output logic [NR_PORTS-1:0]            gnt_o,
    output logic [NR_PORTS-1:0]            rvalid_o,
    output logic [NR_PORTS-1:0]            err_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           req_o,
    output logic                           we_o,
    output logic [ADDR_WIDTH-1:0]          addr_o,
    output logic [DATA_WIDTH-1:0]          wdata_o,
    input  logic                           gnt_i,
    input  logic                           rvalid_i,
    input  logic [DATA_WIDTH-1:0]          rdata_i
);
    localparam int IW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d, rr_q, rr_d, sel;
    logic                  found;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // first requester strictly after the previous winner, wrapping around
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= NR_PORTS; i++) begin
            if (!found && req_i[(int'(rr_q) + i) % NR_PORTS]) begin
                found = 1'b1;
                sel   = IW'((int'(rr_q) + i) % NR_PORTS);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt_o    = '0;
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        unique case (state_q)
            IDLE: if (found) begin
                state_d = REQ;
                idx_d   = sel;
                rr_d    = sel;
                we_d    = we_i[sel];
                addr_d  = addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_d = wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            end
            REQ: if (gnt_i) begin
                gnt_o[idx_q] = 1'b1;
                cnt_d        = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (rvalid_i) begin
                    rvalid_o[idx_q] = 1'b1;
                    rdata_o         = rdata_i;
                    state_d         = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rvalid_o[idx_q] = 1'b1;
                    err_o[idx_q]    = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rr_q    <= IW'(NR_PORTS - 1);
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign req_o   = (state_q == REQ);
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: tb/tb_clint_reg_arbiter.sv
// tb_clint_reg_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_clint_reg_arbiter;
    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int TO = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NP-1:0]     req_i, we_i;
    logic [NP*AW-1:0]  addr_i;
    logic [NP*DW-1:0]  wdata_i;
    logic [NP-1:0]     gnt_o, rvalid_o, err_o;
    logic [DW-1:0]     rdata_o;
    logic              req_o, we_o;
    logic [AW-1:0]     addr_o;
    logic [DW-1:0]     wdata_o;
    logic              gnt_i, rvalid_i;
    logic [DW-1:0]     rdata_i;

    int total = 0;
    int passed = 0;

    clint_reg_arbiter #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o),
        .rdata_o(rdata_o), .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // inputs change 1 time unit after the rising edge, outputs are checked 1 unit later
    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs;
        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    endtask

    task automatic do_reset;
        rst_ni = 1'b0;
        clear_inputs();
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        req_i = '1; we_i = '1; addr_i = '1; wdata_i = '1;
        gnt_i = 1'b1; rvalid_i = 1'b1; rdata_i = 64'hCAFE_F00D_1234_5678;
        step();
        step();
        #1;
        total++; if (req_o !== 1'b0) $display("FAIL reset_req_o: got %b want 0", req_o); else passed++;
        total++; if (we_o !== 1'b0) $display("FAIL reset_we_o: got %b want 0", we_o); else passed++;
        total++; if (addr_o !== '0) $display("FAIL reset_addr_o: got %h want 0", addr_o); else passed++;
        total++; if (wdata_o !== '0) $display("FAIL reset_wdata_o: got %h want 0", wdata_o); else passed++;
        total++; if (gnt_o !== '0) $display("FAIL reset_gnt_o: got %b want 0", gnt_o); else passed++;
        total++; if (rvalid_o !== '0) $display("FAIL reset_rvalid_o: got %b want 0", rvalid_o); else passed++;
        total++; if (err_o !== '0) $display("FAIL reset_err_o: got %b want 0", err_o); else passed++;
        total++; if (rdata_o !== '0) $display("FAIL reset_rdata_o: got %h want 0", rdata_o); else passed++;
        clear_inputs();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic test_single_read;
        req_i = 4'b0100;
        addr_i[2*AW +: AW] = 16'hBFF8;
        #1;
        total++; if (req_o !== 1'b0) $display("FAIL single_idle_req: got %b want 0", req_o); else passed++;
        step();
        gnt_i = 1'b1;
        #1;
        total++; if (req_o !== 1'b1 || addr_o !== 16'hBFF8 || we_o !== 1'b0)
            $display("FAIL single_cmd: got req=%b addr=%h we=%b want req=1 addr=bff8 we=0", req_o, addr_o, we_o);
        else passed++;
        total++; if (gnt_o !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", gnt_o); else passed++;
        step();
        req_i = '0; gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 64'h1234;
        #1;
        total++; if (rvalid_o !== 4'b0100 || err_o !== '0 || rdata_o !== 64'h1234)
            $display("FAIL single_rsp: got rvalid=%b err=%b rdata=%h want 0100/0000/1234", rvalid_o, err_o, rdata_o);
        else passed++;
        total++; if (req_o !== 1'b0 || gnt_o !== '0) $display("FAIL single_req_len: got req=%b gnt=%b want 0/0000", req_o, gnt_o); else passed++;
        step();
        rvalid_i = 1'b0;
        #1;
        total++; if (rvalid_o !== '0 || rdata_o !== '0) $display("FAIL single_after: got rvalid=%b rdata=%h want 0/0", rvalid_o, rdata_o); else passed++;
    endtask

    task automatic test_fairness;
        int seen [NP];
        do_reset();
        foreach (seen[p]) seen[p] = 0;
        for (int t = 0; t < 2 * NP; t++) begin
            req_i = '1;
            step();
            gnt_i = 1'b1;
            #1;
            total++; if (gnt_o !== 4'(1 << (t % NP))) $display("FAIL fair_gnt_%0d: got %b want %b", t, gnt_o, 4'(1 << (t % NP))); else passed++;
            for (int p = 0; p < NP; p++) if (gnt_o[p]) seen[p]++;
            step();
            gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 64'(t);
            #1;
            total++; if (rvalid_o !== 4'(1 << (t % NP))) $display("FAIL fair_rvalid_%0d: got %b want %b", t, rvalid_o, 4'(1 << (t % NP))); else passed++;
            step();
            rvalid_i = 1'b0;
        end
        for (int p = 0; p < NP; p++) begin
            total++; if (seen[p] != 2) $display("FAIL fair_count_%0d: got %0d want 2", p, seen[p]); else passed++;
        end
        req_i = '0;
    endtask

    task automatic test_backpressure;
        int pulses = 0;
        step();
        req_i = 4'b0010; we_i = 4'b0010;
        addr_i[1*AW +: AW] = 16'h4008;
        wdata_i[1*DW +: DW] = 64'h5;
        step();
        for (int k = 0; k < 6; k++) begin
            gnt_i = (k == 5);
            #1;
            total++; if (req_o !== 1'b1 || we_o !== 1'b1 || addr_o !== 16'h4008 || wdata_o !== 64'h5)
                $display("FAIL bp_hold_%0d: got req=%b we=%b addr=%h wdata=%h want 1/1/4008/5", k, req_o, we_o, addr_o, wdata_o);
            else passed++;
            total++; if (gnt_o !== ((k == 5) ? 4'b0010 : 4'b0000)) $display("FAIL bp_gnt_%0d: got %b", k, gnt_o); else passed++;
            pulses += int'(gnt_o[1]);
            step();
        end
        req_i = '0; we_i = '0; gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = '0;
        #1;
        total++; if (pulses != 1 || gnt_o !== '0) $display("FAIL bp_pulses: got %0d gnt=%b want 1 pulse", pulses, gnt_o); else passed++;
        total++; if (rvalid_o !== 4'b0010 || err_o !== '0) $display("FAIL bp_rsp: got rvalid=%b err=%b want 0010/0000", rvalid_o, err_o); else passed++;
        step();
        rvalid_i = 1'b0;
    endtask

    task automatic test_timeout;
        req_i = 4'b1000;
        addr_i[3*AW +: AW] = 16'hBFF8;
        step();
        gnt_i = 1'b1;
        #1;
        total++; if (gnt_o !== 4'b1000) $display("FAIL to_gnt: got %b want 1000", gnt_o); else passed++;
        step();
        req_i = '0; gnt_i = 1'b0; rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
        for (int k = 0; k < TO; k++) begin
            #1;
            if (k < TO - 1) begin
                total++; if (rvalid_o !== '0 || err_o !== '0 || rdata_o !== '0)
                    $display("FAIL to_wait_%0d: got rvalid=%b err=%b rdata=%h want 0", k, rvalid_o, err_o, rdata_o);
                else passed++;
            end else begin
                total++; if (rvalid_o !== 4'b1000 || err_o !== 4'b1000 || rdata_o !== '0)
                    $display("FAIL to_err: got rvalid=%b err=%b rdata=%h want 1000/1000/0", rvalid_o, err_o, rdata_o);
                else passed++;
            end
            step();
        end
        rvalid_i = 1'b1;
        #1;
        total++; if (rvalid_o !== '0 || err_o !== '0 || rdata_o !== '0)
            $display("FAIL to_late: got rvalid=%b err=%b rdata=%h want 0", rvalid_o, err_o, rdata_o);
        else passed++;
        step();
        rvalid_i = 1'b0;
        #1;
        total++; if (req_o !== 1'b0) $display("FAIL to_idle: got req=%b want 0", req_o); else passed++;
    endtask

    task automatic test_simultaneous;
        req_i = 4'b0001;
        step();
        gnt_i = 1'b1;
        step();
        req_i = '0; gnt_i = 1'b0;
        for (int k = 0; k < TO; k++) begin
            rvalid_i = (k == TO - 1);
            rdata_i = 64'hA5A5_0000_1111_2222 + 64'(k);
            #1;
            if (k == TO - 1) begin
                total++; if (rvalid_o !== 4'b0001 || err_o !== '0 || rdata_o !== rdata_i)
                    $display("FAIL simul_rsp: got rvalid=%b err=%b rdata=%h want 0001/0000/%h", rvalid_o, err_o, rdata_o, rdata_i);
                else passed++;
            end
            step();
        end
        rvalid_i = 1'b0;
        #1;
        total++; if (rvalid_o !== '0 || req_o !== 1'b0) $display("FAIL simul_after: got rvalid=%b req=%b want 0/0", rvalid_o, req_o); else passed++;
    endtask

    task automatic test_reset_mid_wait;
        req_i = 4'b0100; we_i = 4'b0100;
        addr_i[2*AW +: AW] = 16'h0010;
        wdata_i[2*DW +: DW] = 64'h0123_4567_89AB_CDEF;
        step();
        gnt_i = 1'b1;
        step();
        req_i = '0; we_i = '0; gnt_i = 1'b0;
        step();
        rst_ni = 1'b0; rvalid_i = 1'b1; rdata_i = 64'h77;
        #1;
        total++; if ({req_o, we_o, gnt_o, rvalid_o, err_o} !== '0 || addr_o !== '0 || wdata_o !== '0 || rdata_o !== '0)
            $display("FAIL rst_mid: got req=%b we=%b gnt=%b rvalid=%b err=%b addr=%h wdata=%h rdata=%h want all 0",
                     req_o, we_o, gnt_o, rvalid_o, err_o, addr_o, wdata_o, rdata_o);
        else passed++;
        step();
        rvalid_i = 1'b0;
        step();
        rst_ni = 1'b1; req_i = '1;
        step();
        gnt_i = 1'b1;
        #1;
        total++; if (gnt_o !== 4'b0001) $display("FAIL rst_first: got %b want 0001", gnt_o); else passed++;
        step();
        req_i = '0; gnt_i = 1'b0; rvalid_i = 1'b1;
        step();
        rvalid_i = 1'b0;
    endtask

    // transaction-level model: pending set, rotating priority, expected response per delay
    task automatic test_random;
        logic [NP-1:0] pend = '0;
        logic          we_m [NP];
        logic [AW-1:0] ad_m [NP];
        logic [DW-1:0] wd_m [NP];
        int            last = NP - 1;
        int            w, gd, rd;
        logic [NP-1:0] oh;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    we_m[p] = 1'($urandom);
                    ad_m[p] = 16'($urandom);
                    wd_m[p] = {$urandom, $urandom};
                    we_i[p] = we_m[p];
                    addr_i[p*AW +: AW] = ad_m[p];
                    wdata_i[p*DW +: DW] = wd_m[p];
                end
            end
            req_i = pend;
            gnt_i = 1'($urandom); rvalid_i = 1'($urandom); rdata_i = {$urandom, $urandom};
            #1;
            total++; if ({req_o, gnt_o, rvalid_o, err_o} !== '0 || rdata_o !== '0)
                $display("FAIL rnd_idle_%0d: got req=%b gnt=%b rvalid=%b err=%b rdata=%h want 0", it, req_o, gnt_o, rvalid_o, err_o, rdata_o);
            else passed++;
            if (pend == '0) begin
                step();
                continue;
            end
            w = -1;
            for (int i = 1; i <= NP; i++) if (w < 0 && pend[(last + i) % NP]) w = (last + i) % NP;
            oh = 4'(1 << w);
            step();
            gd = $urandom_range(0, 3);
            for (int k = 0; k <= gd; k++) begin
                gnt_i = (k == gd); rvalid_i = 1'($urandom);
                #1;
                total++; if (req_o !== 1'b1 || we_o !== we_m[w] || addr_o !== ad_m[w] || wdata_o !== wd_m[w] || rvalid_o !== '0 || gnt_o !== ((k == gd) ? oh : 4'b0))
                    $display("FAIL rnd_req_%0d: got req=%b we=%b addr=%h gnt=%b rvalid=%b want port %0d we=%b addr=%h gnt_at=%0d",
                             it, req_o, we_o, addr_o, gnt_o, rvalid_o, w, we_m[w], ad_m[w], gd);
                else passed++;
                step();
            end
            pend[w] = 1'b0;
            req_i = pend;
            rd = $urandom_range(0, TO + 1);
            for (int k = 0; k < TO; k++) begin
                rvalid_i = (k == rd); gnt_i = 1'($urandom); rdata_i = {$urandom, $urandom};
                #1;
                if (k == rd) begin
                    total++; if (rvalid_o !== oh || err_o !== '0 || rdata_o !== rdata_i || gnt_o !== '0)
                        $display("FAIL rnd_rsp_%0d: got rvalid=%b err=%b rdata=%h want %b/0000/%h", it, rvalid_o, err_o, rdata_o, oh, rdata_i);
                    else passed++;
                end else if (k == TO - 1) begin
                    total++; if (rvalid_o !== oh || err_o !== oh || rdata_o !== '0 || gnt_o !== '0)
                        $display("FAIL rnd_to_%0d: got rvalid=%b err=%b rdata=%h want %b/%b/0", it, rvalid_o, err_o, rdata_o, oh, oh);
                    else passed++;
                end else begin
                    total++; if (rvalid_o !== '0 || err_o !== '0 || rdata_o !== '0 || gnt_o !== '0 || req_o !== 1'b0)
                        $display("FAIL rnd_wait_%0d_%0d: got rvalid=%b err=%b gnt=%b req=%b want 0", it, k, rvalid_o, err_o, gnt_o, req_o);
                    else passed++;
                end
                step();
                if (k == rd) break;
            end
            last = w;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_ni = 1'b0;
        test_reset();
        test_single_read();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_simultaneous();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
